pit_content_buffer: RTL and testbench

- Consumer side of the PIT lookup interface. Acts on each PIT result (pit_in_bit / rejected with table_entry, meta_data, interest_packet).
- Stores FIB-delivered content bytes into the slot addressed by the PIT entry. Serves stored content back to the user on an interest hit.
- On an interest miss, records a pending interest and forwards a miss request. Drains and counts rejected data packets.

---
 rtl/pit_content_buffer.sv | 172 +++++++++++++++++
 tb/tb_pit_content_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pit_content_buffer.sv
// Consumer of PIT lookup results: fills per-slot content from the FIB side,
// serves it to the user on interest hits, forwards misses and drains rejects.
//
// state | meaning
// IDLE  | waiting for a PIT result or reject
// WRITE | accepting len bytes into the latched slot
// READ  | streaming len bytes of the latched slot to the user
// DRAIN | consuming and discarding len bytes of a rejected packet
module pit_content_buffer #(
   parameter int SLOT_W  = 4,
   parameter int MAX_LEN = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pit_in_bit,
   input  logic        rejected,
   input  logic [10:0] table_entry,
   input  logic [7:0]  meta_data,
   input  logic        interest_packet,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_last,
   input  logic        out_ready,
   output logic        miss_fwd,
   output logic [9:0]  miss_addr,
   output logic        busy,
   output logic        event_lost,
   output logic [15:0] drop_count
);
   localparam int NSLOT = 2 ** SLOT_W;
   localparam int IDX_W = $clog2(MAX_LEN);
   localparam int LEN_W = IDX_W + 1;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t                     state;
   logic [SLOT_W-1:0]          slot_q;
   logic [LEN_W-1:0]           len_q;
   logic [IDX_W-1:0]           idx;
   logic                       ip_q;
   logic [NSLOT-1:0]           slot_valid;
   logic [NSLOT-1:0]           pending;
   logic [LEN_W-1:0]           slot_len [NSLOT];
   logic [7:0]                 mem [NSLOT*MAX_LEN];

   logic [SLOT_W-1:0]          ev_slot;
   logic [LEN_W-1:0]           ev_len;
   logic                       ev_interest;
   logic [IDX_W-1:0]           idx_nxt;
   logic                       idx_last;
   logic                       nxt_last;
   logic                       wr_en;
   logic [SLOT_W+IDX_W-1:0]    rd_addr;

   assign ev_slot     = table_entry[SLOT_W-1:0];
   // A zero length field encodes a full slot
   assign ev_len      = (meta_data[5:0] == 6'd0) ? LEN_W'(MAX_LEN) : LEN_W'(meta_data[5:0]);
   assign ev_interest = (meta_data[7:6] == 2'b01);
   assign idx_nxt     = idx + IDX_W'(1);
   assign idx_last    = ({1'b0, idx} == (len_q - LEN_W'(1)));
   assign nxt_last    = ({1'b0, idx_nxt} == (len_q - LEN_W'(1)));
   assign wr_en       = (state == WRITE) && in_valid && in_ready;
   assign rd_addr     = out_valid ? {slot_q, idx_nxt} : {slot_q, idx};
   assign busy        = (state != IDLE);

   always_ff @(posedge clk) begin
      if (wr_en) mem[{slot_q, idx}] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         slot_q     <= '0;
         len_q      <= '0;
         idx        <= '0;
         ip_q       <= 1'b0;
         slot_valid <= '0;
         pending    <= '0;
         for (int i = 0; i < NSLOT; i++) slot_len[i] <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= 8'd0;
         out_last   <= 1'b0;
         miss_fwd   <= 1'b0;
         miss_addr  <= 10'd0;
         event_lost <= 1'b0;
         drop_count <= 16'd0;
      end else begin
         miss_fwd   <= 1'b0;
         event_lost <= (state != IDLE) && (pit_in_bit || rejected);
         case (state)
            IDLE: begin
               idx <= '0;
               if (rejected) begin
                  state    <= DRAIN;
                  len_q    <= ev_len;
                  in_ready <= 1'b1;
               end else if (pit_in_bit) begin
                  if (ev_interest) begin
                     if (slot_valid[ev_slot]) begin
                        state  <= READ;
                        slot_q <= ev_slot;
                        len_q  <= slot_len[ev_slot];
                     end else begin
                        pending[ev_slot] <= 1'b1;
                        miss_fwd         <= 1'b1;
                        miss_addr        <= table_entry[9:0];
                     end
                  end else begin
                     state    <= WRITE;
                     slot_q   <= ev_slot;
                     len_q    <= ev_len;
                     ip_q     <= interest_packet;
                     in_ready <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (in_valid && in_ready) begin
                  idx <= idx_nxt;
                  if (idx_last) begin
                     in_ready           <= 1'b0;
                     slot_valid[slot_q] <= 1'b1;
                     slot_len[slot_q]   <= len_q;
                     idx                <= '0;
                     if (pending[slot_q] || ip_q) begin
                        pending[slot_q] <= 1'b0;
                        state           <= READ;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
            end
            READ: begin
               // First cycle loads byte 0; afterwards each handshake loads the next
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= mem[rd_addr];
                  out_last  <= idx_last;
               end else if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     idx       <= '0;
                     state     <= IDLE;
                  end else begin
                     idx      <= idx_nxt;
                     out_data <= mem[rd_addr];
                     out_last <= nxt_last;
                  end
               end
            end
            DRAIN: begin
               if (in_valid) begin
                  idx <= idx_nxt;
                  if (idx_last) begin
                     in_ready <= 1'b0;
                     idx      <= '0;
                     state    <= IDLE;
                     if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pit_content_buffer.sv
// Directed bench for pit_content_buffer: write/hit, miss/fill, drain,
// full-length slot, back-pressure, collisions and reset mid-read.
module tb_pit_content_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pit_in_bit = 1'b0;
   logic        rejected = 1'b0;
   logic [10:0] table_entry = '0;
   logic [7:0]  meta_data = '0;
   logic        interest_packet = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_ready = 1'b0;
   logic        miss_fwd;
   logic [9:0]  miss_addr;
   logic        busy;
   logic        event_lost;
   logic [15:0] drop_count;

   int vecs = 0;
   int errs = 0;

   pit_content_buffer dut (
      .clk(clk), .rst(rst), .pit_in_bit(pit_in_bit), .rejected(rejected),
      .table_entry(table_entry), .meta_data(meta_data), .interest_packet(interest_packet),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .miss_fwd(miss_fwd), .miss_addr(miss_addr), .busy(busy),
      .event_lost(event_lost), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one event for a single clock edge; returns at the following negedge.
   task automatic ev(input logic pit, input logic rej, input logic [10:0] entry,
                     input logic [7:0] meta, input logic ip);
      pit_in_bit = pit; rejected = rej; table_entry = entry;
      meta_data = meta; interest_packet = ip;
      @(negedge clk);
      pit_in_bit = 1'b0; rejected = 1'b0; interest_packet = 1'b0;
   endtask

   // Push n bytes base, base+step, ...; optionally collide an event on beat 'collide'.
   task automatic feed(input int n, input logic [7:0] base, input logic [7:0] step,
                       input int collide);
      for (int i = 0; i < n; i++) begin
         int t;
         t = 0;
         in_valid = 1'b1;
         in_data  = 8'(base + 8'(i) * step);
         while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t == 50) check("feed_timeout", 32'(i), 32'(n));
         if (i == collide) begin
            pit_in_bit = 1'b1; meta_data = 8'h44; table_entry = 11'h003;
         end
         @(negedge clk);
         pit_in_bit = 1'b0;
         if (i == collide) check("event_lost", 32'(event_lost), 32'd1);
      end
      in_valid = 1'b0;
   endtask

   // Receive n bytes with out_ready following pattern[c%4] per cycle.
   task automatic receive(input int n, input logic [7:0] base, input logic [7:0] step,
                          input logic [3:0] pattern, input string tag);
      int k, c;
      logic stalled;
      logic [7:0] held;
      logic [7:0] exp;
      k = 0; c = 0; stalled = 1'b0; held = '0;
      while (k < n && c < 400) begin
         out_ready = pattern[c % 4];
         if (out_valid) begin
            if (stalled) check({tag, "_stall"}, 32'(out_data), 32'(held));
            if (out_ready) begin
               exp = 8'(base + 8'(k) * step);
               check({tag, "_data"}, 32'(out_data), 32'(exp));
               check({tag, "_last"}, 32'(out_last), 32'(k == n - 1));
               k++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = out_data;
            end
         end
         @(negedge clk);
         c++;
      end
      out_ready = 1'b0;
      if (k < n) check({tag, "_timeout"}, 32'(k), 32'(n));
      check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_data"}, 32'(out_data), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_miss_fwd"}, 32'(miss_fwd), 32'd0);
      check({tag, "_miss_addr"}, 32'(miss_addr), 32'd0);
      check({tag, "_drop"}, 32'(drop_count), 32'd0);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // data write to slot 3, then interest hit
      ev(1'b1, 1'b0, 11'h003, 8'h84, 1'b0);
      check("wr_busy", 32'(busy), 32'd1);
      check("wr_in_ready", 32'(in_ready), 32'd1);
      feed(4, 8'h01, 8'h01, -1);
      check("wr_done_ready", 32'(in_ready), 32'd0);
      check("wr_done_busy", 32'(busy), 32'd0);
      ev(1'b1, 1'b0, 11'h403, 8'h44, 1'b0);
      receive(4, 8'h01, 8'h01, 4'hF, "hit");

      // miss then fill with auto delivery
      ev(1'b1, 1'b0, 11'h005, 8'h44, 1'b0);
      check("miss_fwd", 32'(miss_fwd), 32'd1);
      check("miss_addr", 32'(miss_addr), 32'h005);
      check("miss_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("miss_fwd_pulse", 32'(miss_fwd), 32'd0);
      ev(1'b1, 1'b0, 11'h005, 8'h82, 1'b0);
      feed(2, 8'hAA, 8'h11, -1);
      check("fill_busy", 32'(busy), 32'd1);
      receive(2, 8'hAA, 8'h11, 4'hF, "fill");

      // reject drain
      ev(1'b0, 1'b1, 11'h000, 8'h83, 1'b0);
      check("drain_ready", 32'(in_ready), 32'd1);
      feed(3, 8'h00, 8'h01, -1);
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_busy", 32'(busy), 32'd0);
      check("drop_1", 32'(drop_count), 32'd1);

      // saturation: preload near the top, then drain twice
      force dut.drop_count = 16'hFFFE;
      @(negedge clk);
      release dut.drop_count;
      for (int r = 0; r < 2; r++) begin
         ev(1'b1, 1'b1, 11'h003, 8'h81, 1'b0);
         feed(1, 8'h00, 8'h00, -1);
         check("drop_sat", 32'(drop_count), 32'hFFFF);
      end
      check("rej_wins_busy", 32'(busy), 32'd0);

      // full-length slot via length 0
      ev(1'b1, 1'b0, 11'h007, 8'h80, 1'b0);
      feed(64, 8'h10, 8'h01, -1);
      check("len64_ready", 32'(in_ready), 32'd0);
      check("len64_busy", 32'(busy), 32'd0);
      ev(1'b1, 1'b0, 11'h407, 8'h44, 1'b0);
      receive(64, 8'h10, 8'h01, 4'hF, "len64");

      // back-pressure re-read of slot 3
      ev(1'b1, 1'b0, 11'h003, 8'h44, 1'b0);
      receive(4, 8'h01, 8'h01, 4'b1001, "bp");

      // collision during write, interest_packet drives delivery
      ev(1'b1, 1'b0, 11'h009, 8'h82, 1'b1);
      feed(2, 8'h11, 8'h11, 0);
      receive(2, 8'h11, 8'h11, 4'hF, "coll");

      // reset mid-read
      ev(1'b1, 1'b0, 11'h403, 8'h44, 1'b0);
      @(negedge clk);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      ev(1'b1, 1'b0, 11'h403, 8'h44, 1'b0);
      check("post_rst_miss", 32'(miss_fwd), 32'd1);
      check("post_rst_addr", 32'(miss_addr), 32'h003);
      check("post_rst_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
